// File: rtl/wb_ram_ws_if.sv
// Wishbone classic bus bundle for wb_ram_ws.
// The master drives the request; the slave returns the termination and the read data.
interface wb_ram_ws_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic                  CYC;
  logic                  STB;
  logic                  WE;
  logic [DATA_W/8-1:0]   SEL;
  logic [ADDR_W-1:0]     ADR;
  logic [DATA_W-1:0]     DAT_O;
  logic [DATA_W-1:0]     DAT_I;
  logic                  ACK;
  logic                  ERR;

  modport master (
    output CYC, STB, WE, SEL, ADR, DAT_O,
    input  DAT_I, ACK, ERR
  );

  modport slave (
    input  CYC, STB, WE, SEL, ADR, DAT_O,
    output DAT_I, ACK, ERR
  );
endinterface

// File: rtl/wb_ram_ws.sv
// Wishbone single-port RAM slave with a programmable number of wait states.
// Out-of-range word addresses terminate with ERR; writes honour byte-lane selects.
module wb_ram_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         rst,
  wb_ram_ws_if.slave   bus
);

  localparam int              SEL_W   = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WS_L    = 4'(WAIT_STATES);
  localparam logic [3:0]      WS_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_s;
  logic                latch_s;

  logic                we_r;
  logic [SEL_W-1:0]    sel_r;
  logic [ADDR_W-1:0]   adr_r;
  logic [DATA_W-1:0]   dat_r;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rdata_r;

  logic                in_range_s;
  logic                resp_s;
  logic                commit_s;
  logic                ack_s;
  logic                err_s;
  logic [ADDR_W-1:0]   rd_adr_s;
  logic                rd_ok_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [IDX_W-1:0]    wr_idx_s;

  // Read address follows the bus while idle so a zero-wait read has its word by RESP
  assign rd_adr_s   = (state_r == IDLE) ? bus.ADR : adr_r;
  assign rd_ok_s    = ({1'b0, rd_adr_s} < DEPTH_L);
  assign rd_idx_s   = rd_adr_s[IDX_W-1:0];
  assign wr_idx_s   = adr_r[IDX_W-1:0];

  assign in_range_s = ({1'b0, adr_r} < DEPTH_L);
  assign resp_s     = (state_r == RESP);
  assign commit_s   = resp_s & rst & bus.CYC & bus.STB & we_r & in_range_s;

  assign ack_s      = resp_s & bus.CYC & in_range_s;
  assign err_s      = resp_s & bus.CYC & ~in_range_s;
  assign bus.ACK    = ack_s;
  assign bus.ERR    = err_s;
  assign bus.DAT_I  = ack_s ? rdata_r : '0;

  // Next-state and wait-counter logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    latch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.CYC && bus.STB) begin
          latch_s = 1'b1;
          if (WS_L != 4'd0) begin
            state_s = WAIT;
            cnt_s   = WS_LOAD;
          end else begin
            state_s = RESP;
            cnt_s   = 4'd0;
          end
        end else begin
          state_s = IDLE;
          cnt_s   = cnt_r;
        end
      end
      WAIT: begin
        if (!bus.CYC) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_s = RESP;
          cnt_s   = 4'd0;
        end else begin
          state_s = WAIT;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and request capture registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      sel_r   <= '0;
      adr_r   <= '0;
      dat_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (latch_s) begin
        we_r  <= bus.WE;
        sel_r <= bus.SEL;
        adr_r <= bus.ADR;
        dat_r <= bus.DAT_O;
      end
    end
  end

  // Byte-lane write port and registered read port; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (commit_s && sel_r[i]) begin
        mem[wr_idx_s][8*i +: 8] <= dat_r[8*i +: 8];
      end
    end
    if (rd_ok_s) begin
      rdata_r <= mem[rd_idx_s];
    end else begin
      rdata_r <= '0;
    end
  end

endmodule

// File: tb/tb_wb_ram_ws.sv
// Self-checking bench for wb_ram_ws: three instances (0, 3 and 2 wait states),
// a vector table driven through a scoreboard, plus abort/reset/back-to-back sequences.
module tb_wb_ram_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [12:0] adr;
  logic [31:0] dat;
  logic [1:0]  dsel;

  logic        ack_s, err_s;
  logic [31:0] dat_i_s;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ack;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          d;
    logic        we;
    logic [3:0]  sel;
    logic [12:0] adr;
    logic [31:0] wd;
    logic        ack;
    logic        err;
    logic        chk;
    logic [31:0] rd;
    logic        scr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[21];

  always #5 clk = ~clk;

  wb_ram_ws_if #(.DATA_W(32), .ADDR_W(13)) bus0 ();
  wb_ram_ws_if #(.DATA_W(32), .ADDR_W(13)) bus1 ();
  wb_ram_ws_if #(.DATA_W(32), .ADDR_W(13)) bus2 ();

  assign bus0.CYC = cyc && (dsel == 2'd0);
  assign bus1.CYC = cyc && (dsel == 2'd1);
  assign bus2.CYC = cyc && (dsel == 2'd2);
  assign bus0.STB = stb;  assign bus1.STB = stb;  assign bus2.STB = stb;
  assign bus0.WE  = we;   assign bus1.WE  = we;   assign bus2.WE  = we;
  assign bus0.SEL = sel;  assign bus1.SEL = sel;  assign bus2.SEL = sel;
  assign bus0.ADR = adr;  assign bus1.ADR = adr;  assign bus2.ADR = adr;
  assign bus0.DAT_O = dat; assign bus1.DAT_O = dat; assign bus2.DAT_O = dat;

  wb_ram_ws #(.DATA_W(32), .ADDR_W(13), .DEPTH(4096), .WAIT_STATES(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  wb_ram_ws #(.DATA_W(32), .ADDR_W(13), .DEPTH(4096), .WAIT_STATES(3))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  wb_ram_ws #(.DATA_W(32), .ADDR_W(13), .DEPTH(4096), .WAIT_STATES(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign ack_s   = (dsel == 2'd0) ? bus0.ACK   : (dsel == 2'd1) ? bus1.ACK   : bus2.ACK;
  assign err_s   = (dsel == 2'd0) ? bus0.ERR   : (dsel == 2'd1) ? bus1.ERR   : bus2.ERR;
  assign dat_i_s = (dsel == 2'd0) ? bus0.DAT_I : (dsel == 2'd1) ? bus1.DAT_I : bus2.DAT_I;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 13'd0; dat = 32'h0;
  endtask

  // one complete transfer with latency, pulse width and idle-data checks
  task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [12:0] a,
                      input logic [31:0] wd, input logic scr, input logic e_ack,
                      input logic e_err, input logic e_chk, input logic [31:0] e_dat);
    exp_t e;
    int   n;
    logic got;
    logic dirty;
    @(negedge clk);
    dsel = 2'(d);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = wd;
    e.ack = e_ack; e.err = e_err; e.chk = e_chk; e.data = e_dat;
    sb.push_back(e);
    got = 1'b0;
    dirty = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack_s || err_s) begin
        got = 1'b1;
        break;
      end
      if (dat_i_s != 32'h0) dirty = 1'b1;
      if (scr) begin
        adr = 13'($urandom); we = ~w; sel = 4'($urandom); dat = $urandom;
      end
    end
    check("response_seen", 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      check("latency", 32'(n), 32'(1 + ws_of(d)));
      check("ack", 32'(ack_s), 32'(e.ack));
      check("err", 32'(err_s), 32'(e.err));
      if (e.chk) check("dat_i", dat_i_s, e.data);
      check("dat_i_zero_while_waiting", 32'(dirty), 32'd0);
      @(posedge clk); #1;
      check("single_cycle_response", 32'(ack_s | err_s), 32'd0);
    end
    release_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   r1, r2, nresp;
    logic flag;
    exp_t e;

    tbl[0]  = '{0, 1'b1, 4'hF, 13'd0,    32'h0BADF00D, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{0, 1'b1, 4'hF, 13'd5,    32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{0, 1'b0, 4'hF, 13'd5,    32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{0, 1'b1, 4'hF, 13'd7,    32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{0, 1'b1, 4'h5, 13'd7,    32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{0, 1'b0, 4'h0, 13'd7,    32'h0,        1'b1, 1'b0, 1'b1, 32'h11BB33DD, 1'b0};
    tbl[6]  = '{0, 1'b1, 4'h0, 13'd7,    32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{0, 1'b0, 4'hF, 13'd7,    32'h0,        1'b1, 1'b0, 1'b1, 32'h11BB33DD, 1'b0};
    tbl[8]  = '{0, 1'b0, 4'hF, 13'd4096, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0};
    tbl[9]  = '{0, 1'b1, 4'hF, 13'd4096, 32'h55555555, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0};
    tbl[10] = '{0, 1'b0, 4'hF, 13'd0,    32'h0,        1'b1, 1'b0, 1'b1, 32'h0BADF00D, 1'b0};
    tbl[11] = '{0, 1'b1, 4'hF, 13'd4095, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[12] = '{0, 1'b0, 4'hF, 13'd4095, 32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678, 1'b0};
    tbl[13] = '{0, 1'b1, 4'hA, 13'd5,    32'h01020304, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[14] = '{0, 1'b0, 4'hF, 13'd5,    32'h0,        1'b1, 1'b0, 1'b1, 32'h01AD03EF, 1'b0};
    tbl[15] = '{1, 1'b1, 4'hF, 13'd3,    32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[16] = '{1, 1'b0, 4'hF, 13'd3,    32'h0,        1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1};
    tbl[17] = '{1, 1'b0, 4'hF, 13'd8191, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0};
    tbl[18] = '{2, 1'b1, 4'hF, 13'd9,    32'h13579BDF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[19] = '{2, 1'b0, 4'hF, 13'd9,    32'h0,        1'b1, 1'b0, 1'b1, 32'h13579BDF, 1'b0};
    tbl[20] = '{2, 1'b1, 4'hF, 13'd10,   32'h2468ACE0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};

    dsel = 2'd0;
    release_bus();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dsel = 2'(k);
      #1;
      check("reset_ack", 32'(ack_s), 32'd0);
      check("reset_err", 32'(err_s), 32'd0);
      check("reset_dat_i", dat_i_s, 32'h0);
    end

    for (int i = 0; i < 21; i++) begin
      xfer(tbl[i].d, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].wd, tbl[i].scr,
           tbl[i].ack, tbl[i].err, tbl[i].chk, tbl[i].rd);
    end

    // abort: CYC dropped in the second cycle after acceptance, 2 wait states
    @(negedge clk);
    dsel = 2'd2;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 13'd9; dat = 32'hFFFF0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0;
    flag = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_s || err_s) flag = 1'b1;
    end
    check("abort_no_response", 32'(flag), 32'd0);
    release_bus();
    xfer(2, 1'b0, 4'hF, 13'd9, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h13579BDF);

    // reset during the wait phase of a write, request held through reset
    @(negedge clk);
    dsel = 2'd1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 13'd3; dat = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_s || err_s) flag = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    release_bus();
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_s || err_s || (dat_i_s != 32'h0)) flag = 1'b1;
    end
    check("reset_abort_no_response", 32'(flag), 32'd0);
    xfer(1, 1'b0, 4'hF, 13'd3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D);

    // back-to-back reads with the request held, 2 wait states
    @(negedge clk);
    dsel = 2'd2;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 13'd9; dat = 32'h0;
    e.ack = 1'b1; e.err = 1'b0; e.chk = 1'b1; e.data = 32'h13579BDF;
    sb.push_back(e);
    e.data = 32'h2468ACE0;
    sb.push_back(e);
    r1 = 0; r2 = 0; nresp = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (ack_s || err_s) begin
        e = sb.pop_front();
        check("b2b_ack", 32'(ack_s), 32'(e.ack));
        check("b2b_dat_i", dat_i_s, e.data);
        nresp++;
        if (nresp == 1) begin
          r1 = n;
          adr = 13'd10;
        end else begin
          r2 = n;
          break;
        end
      end
    end
    @(posedge clk); #1;
    release_bus();
    check("b2b_responses", 32'(nresp), 32'd2);
    check("b2b_first_latency", 32'(r1), 32'd3);
    check("b2b_period", 32'(r2 - r1), 32'd4);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
